vga_sync_generator: RTL and testbench
=====================================

# vga_sync_generator

Generates 800x600 @ 72 Hz VGA timing from a 50 MHz clock and drives hsync, vsync and 12-bit RGB. Sits directly upstream of the VGA controller stage, which rebuilds display column/row from these syncs. Fetches pixels from a fixed-latency pixel source through a request/valid interface, blanks RGB outside the visible area, and flags pixel underflow.

## Interface

- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch (clocks)
- H_SYNC, 120, hsync pulse width
- H_BACK, 64, horizontal back porch
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width
- V_BACK, 23, vertical back porch
- clock  in  1  50 MHz pixel clock; single clock domain
- reset  in  1  synchronous, active-high
- pixel_in  in  12  RGB444 {R[11:8],G[7:4],B[3:0]} from source
- pixel_valid  in  1  pixel_in valid; must answer pixel_req exactly one cycle later
- pixel_req  out  1  request for pixel at req_col/req_row
- req_col  out  12  column of requested pixel
- req_row  out  11  row of requested pixel
- hsync  out  1  horizontal sync, active-high
- vsync  out  1  vertical sync, active-high
- rgb_out  out  12  pixel colour; 0 when blanked
- visible  out  1  output pixel is inside 800x600
- display_col  out  12  column of output pixel
- display_row  out  11  row of output pixel
- frame_start  out  1  one-cycle pulse with output pixel (0,0)
- underflow  out  1  sticky; pixel_valid missing on a visible pixel

## Operation

- Stage 0: h_count 0..H_TOTAL-1 (H_TOTAL = 1040), v_count 0..V_TOTAL-1 (V_TOTAL = 666). h wraps 1039→0; v increments only on h wrap; v wraps 665→0 on the same edge h wraps.
- Line order: visible [0,799], front porch [800,855], sync [856,975], back porch [976,1039]. Frame order: visible [0,599], front [600,636], sync [637,642], back [643,665].
- Stage 1 (registered from stage 0): pixel_req = (h<800 && v<600); req_col/req_row = h/v when requesting, else 0; sync/visible flags and position carried along.
- Stage 2 (registered from stage 1): hsync, vsync, visible, display_col, display_row. rgb_out = pixel_in if stage-1 visible && pixel_valid; 0 if not visible; 0 and underflow set if visible && !pixel_valid.
- frame_start = stage-1 position (0,0), registered into stage 2.
- pixel_valid while not requested is ignored; it never sets underflow.
- underflow clears only on reset.
- All outputs are registered; no combinational input-to-output path.

## Timing

- Reset: counters (0,0); all outputs 0 (hsync, vsync, visible, rgb_out, pixel_req, req_col, req_row, display_col, display_row, frame_start, underflow).
- First edge with reset low: pixel_req=1 for (0,0). Second edge: frame_start=1, visible=1, display (0,0).
- Request-to-output latency: 1 clock. Counter-to-output latency: 2 clocks, identical for syncs, position and RGB.
- Line = 1040 clocks; frame = 692 640 clocks; frame_start period equals frame length.
- Reset mid-frame: on the next edge all outputs return to reset values and the pipeline is flushed; restart sequence identical to power-on.

## Configuration

- VGA_TEST_PATTERN_EN defined: internal colour bars replace pixel_in — 8 vertical bars, 100 px each, order white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000. pixel_req and req_col/req_row held 0, pixel_in/pixel_valid ignored, underflow stays 0. Sync timing unchanged.
- Undefined: RGB from pixel_in as in Operation.

## Structure

- Package vga_timing_pkg: timing constants, derived H_TOTAL/V_TOTAL and sync window bounds, RGB444 type, colour-bar table.
- Sub-module vga_timing_counter: stage-0 h/v counters and wrap logic; top level holds pipeline, pixel interface and test pattern.

## Test plan

- Reset then run 2 lines -> pixel_req high 800 clocks per line; hsync high exactly 120 clocks, rising 856 clocks after display_col 0; line period 1040.
- Run 2 full frames -> frame_start period 692 640; vsync high 6 lines, rising at output row 637, col 0.
- Source echoes pixel_in = {req_col[3:0], req_row[3:0], 4'h5} with valid one cycle later -> rgb_out matches display_col/row; rgb_out = 0 whenever visible = 0.
- Drop pixel_valid once at (400,300) -> rgb_out = 000 for that pixel, underflow rises next edge and stays high; pixel_valid pulse during blanking on a fresh run -> underflow stays 0.
- Assert reset at (500,200) for 1 clock -> all outputs 0 next edge; frame_start 2 clocks after release.
- VGA_TEST_PATTERN_EN build -> row 0 cols 0, 99, 100, 799 give FFF, FFF, FF0, 000; pixel_req never asserts.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 800x600 @ 72 Hz timing constants, counter types and colour-bar table.
// Shared by vga_timing_counter and vga_sync_generator.

package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 800;
    localparam int unsigned H_FRONT   = 56;
    localparam int unsigned H_SYNC    = 120;
    localparam int unsigned H_BACK    = 64;
    localparam int unsigned V_VISIBLE = 600;
    localparam int unsigned V_FRONT   = 37;
    localparam int unsigned V_SYNC    = 6;
    localparam int unsigned V_BACK    = 23;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned HCOUNT_W = 12;
    localparam int unsigned VCOUNT_W = 11;

    typedef logic [HCOUNT_W-1:0] hcount_t;
    typedef logic [VCOUNT_W-1:0] vcount_t;
    typedef logic [11:0]         rgb444_t;

    // Window bounds are half-open: [start, stop)
    localparam hcount_t H_VIS_END    = hcount_t'(H_VISIBLE);
    localparam hcount_t H_SYNC_START = hcount_t'(H_VISIBLE + H_FRONT);
    localparam hcount_t H_SYNC_STOP  = hcount_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam hcount_t H_LAST       = hcount_t'(H_TOTAL - 1);
    localparam vcount_t V_VIS_END    = vcount_t'(V_VISIBLE);
    localparam vcount_t V_SYNC_START = vcount_t'(V_VISIBLE + V_FRONT);
    localparam vcount_t V_SYNC_STOP  = vcount_t'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam vcount_t V_LAST       = vcount_t'(V_TOTAL - 1);

    localparam int unsigned BAR_WIDTH = 100;
    localparam int unsigned NUM_BARS  = 8;

    localparam rgb444_t BAR_COLORS [NUM_BARS] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // Colour of the bar covering a visible column; scans from the right so the
    // leftmost matching bar wins.
    function automatic rgb444_t bar_color(hcount_t col);
        rgb444_t c;
        c = BAR_COLORS[NUM_BARS-1];
        for (int i = NUM_BARS - 1; i >= 0; i--) begin
            if (col < hcount_t'((i + 1) * BAR_WIDTH)) begin
                c = BAR_COLORS[3'(i)];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: stage-0 horizontal/vertical position counters.
// h runs 0..H_TOTAL-1; v advances only when h wraps and wraps on the same edge.

module vga_timing_counter
    import vga_timing_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    output hcount_t h_count,
    output vcount_t v_count
);

    hcount_t h_next;
    vcount_t v_next;

    // Next position with line and frame wrap
    always_comb begin
        h_next = h_count + 1'b1;
        v_next = v_count;
        if (h_count == H_LAST) begin
            h_next = '0;
            v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end
    end

    // Position register, synchronous reset to (0,0)
    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: 800x600 @ 72 Hz sync/RGB generator with a 1-cycle pixel fetch.
// Stage 0 counts, stage 1 requests the pixel, stage 2 drives syncs, position and RGB.
// Define VGA_TEST_PATTERN_EN to replace pixel_in with internal colour bars.

module vga_sync_generator
    import vga_timing_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] pixel_in,
    input  logic        pixel_valid,
    output logic        pixel_req,
    output logic [11:0] req_col,
    output logic [10:0] req_row,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb_out,
    output logic        visible,
    output logic [11:0] display_col,
    output logic [10:0] display_row,
    output logic        frame_start,
    output logic        underflow
);

    hcount_t h_count;
    vcount_t v_count;

    vga_timing_counter u_counter (
        .clock   (clock),
        .reset   (reset),
        .h_count (h_count),
        .v_count (v_count)
    );

    logic    s0_visible, s0_hsync, s0_vsync;
    logic    s1_visible, s1_hsync, s1_vsync;
    hcount_t s1_col;
    vcount_t s1_row;
    rgb444_t rgb_next;
    logic    underflow_next;
    logic    frame_next;

    // Stage-0 region decode
    always_comb begin
        s0_visible = (h_count < H_VIS_END) && (v_count < V_VIS_END);
        s0_hsync   = (h_count >= H_SYNC_START) && (h_count < H_SYNC_STOP);
        s0_vsync   = (v_count >= V_SYNC_START) && (v_count < V_SYNC_STOP);
    end

    // Stage 1: issue pixel request and carry position/flags along
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_visible <= 1'b0;
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
            pixel_req  <= 1'b0;
            req_col    <= '0;
            req_row    <= '0;
        end else begin
            s1_visible <= s0_visible;
            s1_hsync   <= s0_hsync;
            s1_vsync   <= s0_vsync;
            s1_col     <= h_count;
            s1_row     <= v_count;
`ifdef VGA_TEST_PATTERN_EN
            pixel_req  <= 1'b0;
            req_col    <= '0;
            req_row    <= '0;
`else
            pixel_req  <= s0_visible;
            req_col    <= s0_visible ? h_count : '0;
            req_row    <= s0_visible ? v_count : '0;
`endif
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic unused_pixel;
    assign unused_pixel = ^{pixel_in, pixel_valid};
`endif

    // Stage-2 colour select, underflow detection and frame marker
    always_comb begin
        // s1_visible gate keeps the reset-cleared (0,0) stage 1 from flagging a frame
        frame_next = s1_visible && (s1_col == '0) && (s1_row == '0);
`ifdef VGA_TEST_PATTERN_EN
        rgb_next       = s1_visible ? bar_color(s1_col) : '0;
        underflow_next = 1'b0;
`else
        rgb_next       = '0;
        underflow_next = underflow;
        if (s1_visible) begin
            if (pixel_valid) begin
                rgb_next = pixel_in;
            end else begin
                underflow_next = 1'b1;
            end
        end
`endif
    end

    // Stage 2: registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            visible     <= 1'b0;
            display_col <= '0;
            display_row <= '0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            hsync       <= s1_hsync;
            vsync       <= s1_vsync;
            visible     <= s1_visible;
            display_col <= s1_col;
            display_row <= s1_row;
            rgb_out     <= rgb_next;
            frame_start <= frame_next;
            underflow   <= underflow_next;
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: directed bench for vga_sync_generator.
// Echoing pixel source, cycle-accurate expected-output model, line-level timing counts,
// underflow drop, mid-frame reset. Colour-bar checks when VGA_TEST_PATTERN_EN is defined.

module tb_vga_sync_generator;

    localparam int H_TOT = 1040;
    localparam int V_TOT = 666;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] pixel_in;
    logic        pixel_valid;
    logic        pixel_req;
    logic [11:0] req_col;
    logic [10:0] req_row;
    logic        hsync, vsync, visible, frame_start, underflow;
    logic [11:0] rgb_out, display_col;
    logic [10:0] display_row;

    always #10 clock = ~clock;

    vga_sync_generator dut (
        .clock       (clock),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_req   (pixel_req),
        .req_col     (req_col),
        .req_row     (req_row),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb_out     (rgb_out),
        .visible     (visible),
        .display_col (display_col),
        .display_row (display_row),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [11:0] tb_bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // Source: answers each request one clock later; can drop one pixel or hold valid high
    int   drop_col = -1;
    int   drop_row = -1;
    int   drop_idx = -1;
    logic src_all_valid = 1'b0;

    initial begin
        pixel_in    = '0;
        pixel_valid = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            pixel_in    = {req_col[3:0], req_row[3:0], 4'h5};
            pixel_valid = src_all_valid ||
                          (pixel_req && !(int'(req_col) == drop_col && int'(req_row) == drop_row));
        end
    end

    // Expected-output model, indexed by edges since reset release
    logic in_reset = 1'b1;
    int   m = 0;

    function automatic logic [63:0] exp_vec(input int mm);
        logic hs, vs, vis, fs, uf, req;
        logic [11:0] dc, rgb, rc;
        logic [10:0] dr, rr;
        int q, p, qc, qr, pc, pr;
        hs = 0; vs = 0; vis = 0; fs = 0; uf = 0; req = 0;
        dc = 0; rgb = 0; rc = 0; dr = 0; rr = 0;
        if (in_reset || mm < 1) return 64'd0;
        q  = mm - 1;
        qc = q % H_TOT;
        qr = (q / H_TOT) % V_TOT;
`ifndef VGA_TEST_PATTERN_EN
        if (qc < 800 && qr < 600) begin
            req = 1'b1;
            rc  = 12'(qc);
            rr  = 11'(qr);
        end
`endif
        if (mm >= 2) begin
            p   = mm - 2;
            pc  = p % H_TOT;
            pr  = (p / H_TOT) % V_TOT;
            dc  = 12'(pc);
            dr  = 11'(pr);
            vis = (pc < 800) && (pr < 600);
            hs  = (pc >= 856) && (pc < 976);
            vs  = (pr >= 637) && (pr < 643);
            fs  = (p % FRAME) == 0;
`ifdef VGA_TEST_PATTERN_EN
            if (vis) rgb = tb_bars[pc / 100];
`else
            if (vis && p != drop_idx) rgb = {pc[3:0], pr[3:0], 4'h5};
            uf = (drop_idx >= 0) && (p >= drop_idx);
`endif
        end
        return {hs, vs, vis, fs, uf, req, dc, dr, rgb, rc, rr};
    endfunction

    function automatic logic [63:0] obs_vec();
        return {hsync, vsync, visible, frame_start, underflow, pixel_req,
                display_col, display_row, rgb_out, req_col, req_row};
    endfunction

    // Per-cycle stream comparison plus first-two-line timing statistics
    int   bad = 0;
    int   first_bad = -1;
    logic stats_en = 1'b1;
    logic prev_hs = 1'b0;
    int   req_cnt [2] = '{0, 0};
    int   hs_cnt  [2] = '{0, 0};
    int   hs_rise [2] = '{-1, -1};
    int   col0_m  [2] = '{-1, -1};
    int   n_rise = 0;
    int   n_col0 = 0;

    task automatic tick();
        @(posedge clock);
        #1;
        m++;
        if (obs_vec() !== exp_vec(m)) begin
            bad++;
            if (first_bad < 0) first_bad = m;
        end
        if (stats_en && !in_reset) begin
            if (pixel_req && m >= 1 && m - 1 < 2 * H_TOT) req_cnt[(m - 1) / H_TOT]++;
            if (hsync && m >= 2 && m - 2 < 2 * H_TOT) hs_cnt[(m - 2) / H_TOT]++;
            if (hsync && !prev_hs && n_rise < 2) begin
                hs_rise[n_rise] = m;
                n_rise++;
            end
            if (visible && display_col == 12'd0 && n_col0 < 2) begin
                col0_m[n_col0] = m;
                n_col0++;
            end
        end
        prev_hs = hsync;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_syncs",   {hsync, vsync, visible, frame_start, underflow}, 0);
        check("rst_rgb",     rgb_out, 0);
        check("rst_req",     {pixel_req, req_col, req_row}, 0);
        check("rst_display", {display_col, display_row}, 0);

        // Power-on sequence
        reset    = 1'b0;
        in_reset = 1'b0;
        m        = 0;
        drop_col = 400;
        drop_row = 2;
        drop_idx = 2 * H_TOT + 400;
        tick();
`ifdef VGA_TEST_PATTERN_EN
        check("edge1_pixel_req", pixel_req, 0);
`else
        check("edge1_pixel_req", pixel_req, 1);
`endif
        check("edge1_req_pos",     {req_col, req_row}, 0);
        check("edge1_frame_start", frame_start, 0);
        check("edge1_visible",     visible, 0);
        tick();
        check("edge2_frame_start", frame_start, 1);
        check("edge2_visible",     visible, 1);
        check("edge2_display_pos", {display_col, display_row}, 0);
`ifdef VGA_TEST_PATTERN_EN
        check("edge2_rgb", rgb_out, 12'hFFF);
`else
        check("edge2_rgb", rgb_out, 12'h005);
`endif

        // Run to output pixel (500,3), spot-checking the drop and colour bars on the way
        while (m - 2 < 3 * H_TOT + 500) begin
            tick();
`ifdef VGA_TEST_PATTERN_EN
            if (m - 2 == 99)  check("tp_col99",  rgb_out, 12'hFFF);
            if (m - 2 == 100) check("tp_col100", rgb_out, 12'hFF0);
            if (m - 2 == 799) check("tp_col799", rgb_out, 12'h000);
            if (m - 2 == 800) check("tp_blank",  rgb_out, 12'h000);
`else
            if (m - 2 == 801) check("blank_rgb_col801", {visible, rgb_out}, 0);
            if (m - 2 == drop_idx - 1) check("pre_drop_underflow", underflow, 0);
            if (m - 2 == drop_idx) begin
                check("drop_pos", {display_col, display_row}, {12'd400, 11'd2});
                check("drop_rgb", rgb_out, 0);
                check("drop_underflow", underflow, 1);
            end
            if (m - 2 == drop_idx + 1) check("post_drop_rgb", rgb_out, {4'h1, 4'h2, 4'h5});
`endif
        end
        stats_en = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
        check("req_count_line0", req_cnt[0], 0);
        check("req_count_line1", req_cnt[1], 0);
        check("underflow_tp", underflow, 0);
`else
        check("req_count_line0", req_cnt[0], 800);
        check("req_count_line1", req_cnt[1], 800);
        check("underflow_sticky", underflow, 1);
`endif
        check("hsync_width_line0",   hs_cnt[0], 120);
        check("hsync_width_line1",   hs_cnt[1], 120);
        check("hsync_rise_offset",   hs_rise[0] - col0_m[0], 856);
        check("line_period_col0",    col0_m[1] - col0_m[0], 1040);
        check("line_period_hsync",   hs_rise[1] - hs_rise[0], 1040);
        check("display_at_500_3",    {display_col, display_row}, {12'd500, 11'd3});
        check("stream_run1_bad",     bad, 0);
        if (first_bad >= 0) $display("first stream deviation at edge %0d", first_bad);

        // One-clock reset in mid-frame
        reset    = 1'b1;
        in_reset = 1'b1;
        tick();
        check("midrst_outputs", obs_vec(), 0);
        reset    = 1'b0;
        in_reset = 1'b0;
        m        = 0;
        bad      = 0;
        first_bad = -1;
        drop_col = -1;
        drop_row = -1;
        drop_idx = -1;
        src_all_valid = 1'b1;
        tick();
        check("restart_edge1_frame_start", frame_start, 0);
        tick();
        check("restart_edge2_frame_start", frame_start, 1);
        check("restart_underflow_cleared", underflow, 0);

        // Fresh run with valid held high through blanking
        while (m - 2 < H_TOT + 100) tick();
        check("blank_valid_underflow", underflow, 0);
        check("stream_run2_bad", bad, 0);
        if (first_bad >= 0) $display("first stream deviation at edge %0d", first_bad);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
